// File: rtl/parser_rule_loader.sv
// Rule-bus master: turns one host command at a time into a single-cycle rule write/read strobe
// and returns one response (read data or timeout/verify error). Optional: RULE_LOADER_WR_VERIFY_EN.
module parser_rule_loader #(
    parameter int RD_TIMEOUT   = 16,
    parameter int WR_CNT_WIDTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [31:0]             i_cmd_addr,
    input  logic [31:0]             i_cmd_wdata,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [31:0]             o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_rule_wren,
    output logic                    o_rule_rden,
    output logic [31:0]             o_rule_addr,
    output logic [31:0]             o_rule_wdata,
    input  logic                    i_rule_rdata_valid,
    input  logic [31:0]             i_rule_rdata,
    output logic                    o_busy,
    output logic [WR_CNT_WIDTH-1:0] o_wr_cnt,
    output logic [7:0]              o_err_cnt,
    output logic [2:0]              o_dbg_state
);

    localparam int CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and the response fields stay stable while valid is held.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR        = 3'd1,
        S_RD        = 3'd2,
        S_RD_WAIT   = 3'd3,
        S_RSP       = 3'd4
`ifdef RULE_LOADER_WR_VERIFY_EN
        ,
        S_VRFY_RD   = 3'd5,
        S_VRFY_WAIT = 3'd6
`endif
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    wren_q, wren_d;
    logic                    rden_q, rden_d;
    logic [CW-1:0]           wait_cnt_q, wait_cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [WR_CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic                    wait_expired;

    // Last permitted wait cycle: the counter starts at 0 in the first wait cycle.
    assign wait_expired = (wait_cnt_q == CW'(RD_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        wr_cnt_d   = wr_cnt_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    addr_d  = i_cmd_addr;
                    wdata_d = i_cmd_wdata;
                    state_d = i_cmd_write ? S_WR : S_RD;
                end
            end
            S_WR: begin
                wr_cnt_d = wr_cnt_q + WR_CNT_WIDTH'(1);
`ifdef RULE_LOADER_WR_VERIFY_EN
                state_d  = S_VRFY_RD;
`else
                rdata_d  = 32'd0;
                err_d    = 1'b0;
                state_d  = S_RSP;
`endif
            end
            S_RD: begin
                wait_cnt_d = '0;
                state_d    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (i_rule_rdata_valid) begin
                    rdata_d = i_rule_rdata;
                    err_d   = 1'b0;
                    state_d = S_RSP;
                end else if (wait_expired) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RSP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
`ifdef RULE_LOADER_WR_VERIFY_EN
            S_VRFY_RD: begin
                wait_cnt_d = '0;
                state_d    = S_VRFY_WAIT;
            end
            S_VRFY_WAIT: begin
                if (i_rule_rdata_valid) begin
                    rdata_d = i_rule_rdata;
                    err_d   = (i_rule_rdata != wdata_q);
                    state_d = S_RSP;
                end else if (wait_expired) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RSP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
`endif
            S_RSP: begin
                if (i_rsp_ready) begin
                    if (err_q && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave a flop aligned with WR/RD.
    always_comb begin
        wren_d = (state_d == S_WR);
        rden_d = (state_d == S_RD);
`ifdef RULE_LOADER_WR_VERIFY_EN
        rden_d = rden_d || (state_d == S_VRFY_RD);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wren_q     <= 1'b0;
            rden_q     <= 1'b0;
            wait_cnt_q <= '0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            wr_cnt_q   <= '0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            rden_q     <= rden_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wr_cnt_q   <= wr_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_cmd_ready  = (state_q == S_IDLE);
    assign o_rsp_valid  = (state_q == S_RSP);
    assign o_busy       = (state_q != S_IDLE);
    assign o_rsp_rdata  = rdata_q;
    assign o_rsp_err    = err_q;
    assign o_rule_wren  = wren_q;
    assign o_rule_rden  = rden_q;
    assign o_rule_addr  = addr_q;
    assign o_rule_wdata = wdata_q;
    assign o_wr_cnt     = wr_cnt_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_parser_rule_loader.sv
// Directed bench for parser_rule_loader: write, read latencies, timeout, backpressure,
// stale read-valid, reset mid-read, error-counter saturation and (with the macro) write verify.
module tb_parser_rule_loader;

  localparam int RD_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rule_wren;
  logic        rule_rden;
  logic [31:0] rule_addr;
  logic [31:0] rule_wdata;
  logic        rule_rdata_valid = 1'b0;
  logic [31:0] rule_rdata = 32'd0;
  logic        busy;
  logic [15:0] wr_cnt;
  logic [7:0]  err_cnt;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  logic [32:0] cur_exp;
  int          exp_wr_cnt = 0;
  int          exp_err_cnt = 0;

  parser_rule_loader #(.RD_TIMEOUT(RD_TIMEOUT), .WR_CNT_WIDTH(16)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_cmd_valid        (cmd_valid),
    .o_cmd_ready        (cmd_ready),
    .i_cmd_write        (cmd_write),
    .i_cmd_addr         (cmd_addr),
    .i_cmd_wdata        (cmd_wdata),
    .o_rsp_valid        (rsp_valid),
    .i_rsp_ready        (rsp_ready),
    .o_rsp_rdata        (rsp_rdata),
    .o_rsp_err          (rsp_err),
    .o_rule_wren        (rule_wren),
    .o_rule_rden        (rule_rden),
    .o_rule_addr        (rule_addr),
    .o_rule_wdata       (rule_wdata),
    .i_rule_rdata_valid (rule_rdata_valid),
    .i_rule_rdata       (rule_rdata),
    .o_busy             (busy),
    .o_wr_cnt           (wr_cnt),
    .o_err_cnt          (err_cnt),
    .o_dbg_state        (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wren"}, 32'(rule_wren), 32'd0);
    check({tag, "_rden"}, 32'(rule_rden), 32'd0);
    check({tag, "_addr"}, rule_addr, 32'd0);
    check({tag, "_wdata"}, rule_wdata, 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  // driver: one write command, checked through to the first response cycle
  task automatic run_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] echo);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_wdata = wdata;
    check("wr_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("wr_wren", 32'(rule_wren), 32'd1);
    check("wr_rden", 32'(rule_rden), 32'd0);
    check("wr_addr", rule_addr, addr);
    check("wr_wdata", rule_wdata, wdata);
    check("wr_busy", 32'(busy), 32'd1);
    exp_wr_cnt++;
`ifdef RULE_LOADER_WR_VERIFY_EN
    exp_q.push_back({(echo !== wdata), echo});
    tick();
    check("vr_wren", 32'(rule_wren), 32'd0);
    check("vr_rden", 32'(rule_rden), 32'd1);
    check("vr_addr", rule_addr, addr);
    check("vr_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    rule_rdata_valid = 1'b1; rule_rdata = echo;
    check("vr_rden_off", 32'(rule_rden), 32'd0);
    check("vr_rsp_early2", 32'(rsp_valid), 32'd0);
    tick();
    rule_rdata_valid = 1'b0;
`else
    exp_q.push_back({1'b0, echo & 32'd0});
    tick();
`endif
    cur_exp = exp_q.pop_front();
    check("wr_wren_off", 32'(rule_wren), 32'd0);
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rsp_rdata", rsp_rdata, cur_exp[31:0]);
    check("wr_rsp_err", 32'(rsp_err), 32'(cur_exp[32]));
    check("wr_cnt", 32'(wr_cnt), 32'(exp_wr_cnt));
  endtask

  // driver: one read command; respond=0 means no responder (timeout)
  task automatic run_read(input logic [31:0] addr, input int lat, input logic respond, input logic [31:0] data);
    int rsp_cyc;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_wdata = 32'h0BAD_0BAD;
    exp_q.push_back(respond ? {1'b0, data} : {1'b1, 32'd0});
    rsp_cyc = respond ? 2 + lat : 2 + RD_TIMEOUT;
    check("rd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("rd_rden", 32'(rule_rden), 32'd1);
    check("rd_wren", 32'(rule_wren), 32'd0);
    check("rd_addr", rule_addr, addr);
    for (int c = 2; c < rsp_cyc; c++) begin
      tick();
      if (respond && (c == 1 + lat)) begin
        rule_rdata_valid = 1'b1; rule_rdata = data;
      end else begin
        rule_rdata_valid = 1'b0;
      end
      check("rd_wait_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rd_wait_rden", 32'(rule_rden), 32'd0);
    end
    tick();
    rule_rdata_valid = 1'b0;
    cur_exp = exp_q.pop_front();
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", rsp_rdata, cur_exp[31:0]);
    check("rd_rsp_err", 32'(rsp_err), 32'(cur_exp[32]));
  endtask

  // driver: consume the pending response and check the error counter model
  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    if (cur_exp[32] && exp_err_cnt != 255) exp_err_cnt++;
    check("hs_rsp_valid", 32'(rsp_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_ready", 32'(cmd_ready), 32'd1);
    check("hs_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
  endtask

  initial begin
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_write(32'h0103_0000, 32'h0000_1234, 32'h0000_1234);
    rsp_handshake();

    run_read(32'h0200_0010, 3, 1'b1, 32'hCAFE_0001);
    // backpressure with a stale read-valid and a competing command
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0F00_0000;
    for (int i = 0; i < 10; i++) begin
      rule_rdata_valid = (i == 3); rule_rdata = 32'hDEAD_BEEF;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'hCAFE_0001);
      check("bp_err", 32'(rsp_err), 32'd0);
      check("bp_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    rule_rdata_valid = 1'b0; cmd_valid = 1'b0;
    check("bp_wren", 32'(rule_wren), 32'd0);
    rsp_handshake();

    run_read(32'h0300_0000, 0, 1'b0, 32'd0);
    rsp_handshake();

    run_read(32'h0200_0020, RD_TIMEOUT, 1'b1, 32'h1357_9BDF);
    rsp_handshake();
    run_read(32'h0200_0030, 1, 1'b1, 32'h0000_0001);
    rsp_handshake();

    // reset asserted while waiting for read data
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0200_0040;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    rule_rdata_valid = 1'b1; rule_rdata = 32'h7777_7777;
    #1;
    check_idle_outputs("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    rule_rdata_valid = 1'b0;
    exp_wr_cnt = 0; exp_err_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    run_write(32'h0105_0004, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
    rsp_handshake();

`ifdef RULE_LOADER_WR_VERIFY_EN
    run_write(32'h0104_0000, 32'h0000_0055, 32'h0000_0054);
    rsp_handshake();
`endif

    // error counter saturation
    for (int i = 0; i < 256; i++) begin
      run_read(32'h0900_0000 + 32'(i), 0, 1'b0, 32'd0);
      rsp_handshake();
    end
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    check("sat_wr_cnt", 32'(wr_cnt), 32'(exp_wr_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
